turbo_intlv_addr: RTL and testbench
===================================

Name: turbo_intlv_addr

Overview:
- Downstream consumer of the turbo length/enable stage.
- Takes the per-pair index stream (enable, pb_offset, valid) and produces interleaved write addresses for the turbo interleaver pair buffer.
- Computes I(x) = (STEP*x + OFS[x mod 8]) mod L incrementally, with no multiplier, in a 2-stage pipeline.
- Output address = pb_offset + I(x), modulo 4096.

Parameters:
- AW, 12, width of index/offset/address buses.
- LAT2, 1, fixed pipeline depth marker. Must be 1; any other value is a synthesis error.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- din_vld  input  1  index valid from upstream dout_vld
- pb_size  input  2  0=PB16 (L=64), 1=PB136 (L=544), 2=PB520 (L=2080), 3=reserved (treated as PB520)
- enable  input  12  pair index x, counts 0..L-1
- pb_offset  input  12  buffer base address for the current PB
- addr  output  12  interleaved buffer address
- dout_vld  output  1  addr valid
- last  output  1  high with dout_vld for the final pair (x=L-1)
- busy  output  1  high while a PB is in progress (state RUN)

Behaviour:
- Reset: addr=0, dout_vld=0, last=0, busy=0, state=IDLE, acc=0, pipeline valids cleared. Async assert, synchronous release.
- STEP per PB size: L=64 → 13; L=544 → 25; L=2080 → 17. All coprime with L.
- OFS table, indexed by x[2:0], identical for all sizes: 0, 24, 8, 40, 16, 56, 32, 48. All values are multiples of 8 and less than 64, so I is a permutation of 0..L-1.
- FSM state IDLE:
  - din_vld=1 with enable=0: latch L/STEP from pb_size, use acc=0 for this pair, go to RUN, busy=1 next cycle.
  - din_vld=1 with enable≠0: beat dropped, no output.
- FSM state RUN:
  - Each din_vld beat uses the current acc, then updates acc ← acc+STEP, minus L if the sum ≥ L.
  - pb_size changes are ignored while in RUN.
  - Beat with enable=L-1 is tagged last; the FSM returns to IDLE the next cycle.
- Gaps: din_vld may drop low for any number of cycles mid-PB. acc and state hold during gaps.
- Stage 1 (registered):
  - s1_sum = acc + OFS[x[2:0]], 13 bits, always < 2L.
  - Also registered: s1_vld, s1_last, s1_base = pb_offset, s1_L.
- Stage 2 (registered):
  - I = s1_sum - L if s1_sum ≥ L, else s1_sum.
  - addr = (s1_base + I) mod 4096; carry discarded.
  - dout_vld = s1_vld; last = s1_last.
- Latency: exactly 2 cycles from an accepted din_vld beat to dout_vld. Throughput is 1 beat per cycle.
- Back-to-back PBs: a beat with enable=0 arriving in the cycle after the last beat (FSM already in IDLE) starts a new PB without bubbles. acc restarts at 0.
- enable=0 while in RUN (upstream restart): abort the current PB, relatch pb_size, and restart with acc=0. Beats already in the pipeline still drain. last is not asserted for the aborted PB.
- Reset mid-PB: the pipeline is flushed and no further dout_vld occurs until a new enable=0 beat.
- Indices in RUN are used as received. Only x[2:0] indexes OFS; acc advances per beat, not per index value.

Optional Feature:
- Macro: TURBO_INTLV_CHK_EN.
- When defined:
  - Adds output err (1 bit, reset 0).
  - In RUN, tracks the expected index (previous+1). A beat whose enable differs from the expected index, other than an enable=0 restart, sets err for 1 cycle, aligned with that beat's dout_vld.
  - A beat dropped in IDLE (enable≠0) pulses err 2 cycles after the beat.
  - Address output behaviour is unchanged.
- When not defined: no err port and no checker logic.

Test Plan:
- PB16, pb_offset=0, x=0..63 contiguous → addr sequence 0, 37, 34, 79%64=15, 68%64=4, 121%64=57, 110%64=46, 139%64=11, …; all 64 addresses distinct; last on the 64th output; dout_vld 2 cycles after each input.
- PB520, pb_offset=100, x=0..2079 with random din_vld gaps → 2080 outputs; {addr-100 mod 4096} is exactly the set 0..2079; last only on the final output; busy low 1 cycle after the final beat is accepted.
- PB136 immediately followed by PB16 (enable=0 the cycle after x=543) → no bubble; second PB starts addr = new pb_offset+0; L switches to 64.
- pb_offset=4000, PB136 → addresses wrap modulo 4096; x=1 gives (4000+49)=4049; x=4 gives (4000+100+16)%4096=20.
- Reset asserted at x=300 of PB520, released, then a beat with enable=5 → no dout_vld; then enable=0 → PB restarts with addr=pb_offset.
- With TURBO_INTLV_CHK_EN: PB16 with x=0,1,2,4 → err pulses with the 4th output only; without the macro, the bench compiles with no err port and addresses are unchanged.

Source files
------------

// File: rtl/turbo_intlv_addr.sv
// -----------------------------------------------------------------------------
// turbo_intlv_addr
//
// Turbo interleaver write-address generator. It consumes the per-pair index
// stream from the length/enable stage and produces interleaved addresses for
// the pair buffer:
//
//   I(x) = (STEP*x + OFS[x mod 8]) mod L
//   addr = (pb_offset + I(x)) mod 2**AW
//
// STEP*x is never multiplied out. An accumulator advances by STEP on every
// accepted beat and wraps at L. The OFS add and the final mod-L fold are split
// across two register stages, so latency is 2 cycles and throughput is 1 beat
// per cycle.
//
// Parameters:
//   AW    width of the index, offset and address buses (12)
//   LAT2  pipeline depth marker. Must be 1; any other value stops elaboration.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   din_vld    index valid (from the upstream dout_vld)
//   pb_size    0=PB16 (L=64), 1=PB136 (L=544), 2/3=PB520 (L=2080)
//   enable     pair index x, counting 0..L-1
//   pb_offset  buffer base address for the current PB
//   addr       interleaved buffer address
//   dout_vld   addr valid
//   last       high with dout_vld for the final pair (x=L-1)
//   busy       high while a PB is in progress
//   err        (TURBO_INTLV_CHK_EN only) index-sequence error pulse
//
// Optional feature: define TURBO_INTLV_CHK_EN to add the index-sequence
// checker and its err output.
// -----------------------------------------------------------------------------
module turbo_intlv_addr #(
    parameter int AW   = 12,
    parameter int LAT2 = 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          din_vld,
    input  logic [1:0]    pb_size,
    input  logic [AW-1:0] enable,
    input  logic [AW-1:0] pb_offset,
    output logic [AW-1:0] addr,
    output logic          dout_vld,
    output logic          last,
    output logic          busy
`ifdef TURBO_INTLV_CHK_EN
    ,
    output logic          err
`endif
);

    generate
        if (LAT2 != 1) begin : g_lat2_bad
            $error("turbo_intlv_addr: LAT2 must be 1");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] l_q, l_d;
    logic [AW-1:0] step_q, step_d;

    logic [AW-1:0] new_l, new_step;
    logic [5:0]    ofs_val;
    logic [AW:0]   acc_sum;
    logic          is_start, is_run_beat, is_drop;
    logic          beat_ok, beat_last;
    logic [AW-1:0] acc_use, l_use;

    logic          s1_vld_q, s1_vld_d;
    logic          s1_last_q, s1_last_d;
    logic [AW:0]   s1_sum_q, s1_sum_d;
    logic [AW-1:0] s1_base_q, s1_base_d;
    logic [AW-1:0] s1_l_q, s1_l_d;

    logic [AW-1:0] i_val;
    logic [AW-1:0] addr_q, addr_d;
    logic          dout_vld_q, dout_vld_d;
    logic          last_q, last_d;

    // Beat classification. Any enable=0 beat starts a PB, or restarts an
    // aborted one. Non-zero indices only count while RUN.
    assign is_start    = din_vld && (enable == '0);
    assign is_run_beat = din_vld && (enable != '0) && (state_q == RUN);
    assign is_drop     = din_vld && (enable != '0) && (state_q == IDLE);
    assign beat_ok     = is_start || is_run_beat;

    // PB geometry for the size presented now. Only latched on a start beat.
    always_comb begin
        unique case (pb_size)
            2'd0:    begin new_l = AW'(64);   new_step = AW'(13); end
            2'd1:    begin new_l = AW'(544);  new_step = AW'(25); end
            default: begin new_l = AW'(2080); new_step = AW'(17); end
        endcase
    end

    // OFS[x mod 8]. The table is the same for every PB size.
    always_comb begin
        unique case (enable[2:0])
            3'd0: ofs_val = 6'd0;
            3'd1: ofs_val = 6'd24;
            3'd2: ofs_val = 6'd8;
            3'd3: ofs_val = 6'd40;
            3'd4: ofs_val = 6'd16;
            3'd5: ofs_val = 6'd56;
            3'd6: ofs_val = 6'd32;
            default: ofs_val = 6'd48;
        endcase
    end

    assign acc_sum = {1'b0, acc_q} + {1'b0, step_q};

    // FSM, accumulator and stage-1 next state.
    always_comb begin
        // NOTE: every output of this block is defaulted first; a path that
        // skipped an assignment would otherwise infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        l_d       = l_q;
        step_d    = step_q;
        acc_use   = acc_q;
        l_use     = l_q;
        beat_last = 1'b0;

        if (is_start) begin
            // This beat uses acc=0, so the next one needs 0+STEP. STEP < L,
            // so no wrap is possible here.
            acc_use = '0;
            l_use   = new_l;
            l_d     = new_l;
            step_d  = new_step;
            acc_d   = new_step;
            state_d = RUN;
        end else if (is_run_beat) begin
            // acc and STEP are both < L, so one conditional subtract wraps
            // the sum. The low bits are exact because the result fits in AW.
            acc_d = (acc_sum >= {1'b0, l_q}) ? (acc_sum[AW-1:0] - l_q) : acc_sum[AW-1:0];
            if (enable == (l_q - AW'(1))) begin
                beat_last = 1'b1;
                state_d   = IDLE;
            end
        end

        // Stage-1 data only loads on accepted beats. The valid bit always
        // loads, so gaps show up as bubbles.
        s1_vld_d  = beat_ok;
        s1_last_d = beat_last;
        s1_sum_d  = beat_ok ? ({1'b0, acc_use} + {{(AW-5){1'b0}}, ofs_val}) : s1_sum_q;
        s1_base_d = beat_ok ? pb_offset : s1_base_q;
        s1_l_d    = beat_ok ? l_use : s1_l_q;
    end

    // Stage 2: fold s1_sum (< 2L) into 0..L-1 and add the base. The carry out
    // of the AW-bit add is dropped, which gives the mod-4096 wrap.
    always_comb begin
        i_val      = (s1_sum_q >= {1'b0, s1_l_q}) ? (s1_sum_q[AW-1:0] - s1_l_q) : s1_sum_q[AW-1:0];
        addr_d     = s1_vld_q ? (s1_base_q + i_val) : addr_q;
        dout_vld_d = s1_vld_q;
        last_d     = s1_vld_q && s1_last_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            // NOTE: the datapath registers are reset along with the control
            // registers, so addr reads 0 out of reset rather than X.
            state_q    <= IDLE;
            acc_q      <= '0;
            l_q        <= '0;
            step_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= '0;
            s1_base_q  <= '0;
            s1_l_q     <= '0;
            addr_q     <= '0;
            dout_vld_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge values no matter what order these statements run in.
            state_q    <= state_d;
            acc_q      <= acc_d;
            l_q        <= l_d;
            step_q     <= step_d;
            s1_vld_q   <= s1_vld_d;
            s1_last_q  <= s1_last_d;
            s1_sum_q   <= s1_sum_d;
            s1_base_q  <= s1_base_d;
            s1_l_q     <= s1_l_d;
            addr_q     <= addr_d;
            dout_vld_q <= dout_vld_d;
            last_q     <= last_d;
        end
    end

    assign addr     = addr_q;
    assign dout_vld = dout_vld_q;
    assign last     = last_q;
    assign busy     = (state_q == RUN);

`ifdef TURBO_INTLV_CHK_EN
    // Index-sequence checker. The error bit travels down the same two stages
    // as the address, so err lines up with the offending beat's dout_vld. A
    // beat dropped in IDLE produces a pulse with no dout_vld beside it.
    logic [AW-1:0] exp_q, exp_d;
    logic          chk_err;
    logic          s1_err_q, err_q;

    always_comb begin
        exp_d   = exp_q;
        chk_err = 1'b0;
        if (is_start) begin
            exp_d = AW'(1);
        end else if (is_run_beat) begin
            chk_err = (enable != exp_q);
            exp_d   = enable + AW'(1);
        end else if (is_drop) begin
            chk_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            exp_q    <= '0;
            s1_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            s1_err_q <= chk_err;
            err_q    <= s1_err_q;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_turbo_intlv_addr.sv
// -----------------------------------------------------------------------------
// tb_turbo_intlv_addr
//
// Directed bench for turbo_intlv_addr. Inputs are driven 1 ns after the rising
// edge. A monitor on the falling edge logs every dout_vld (address, last and
// cycle) and every err pulse. Each test task drives its scenario and then
// compares the log against hand-computed constants and a closed-form model
// (STEP*x + OFS) mod L.
//
// Cycle bookkeeping: cyc counts rising edges. A beat is logged with the cyc
// value just after the edge that samples it, and its output appears one edge
// later. In this log, a 2-cycle latency therefore shows up as
// out_cyc == in_cyc + 1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_turbo_intlv_addr;

    logic        clk       = 1'b0;
    logic        n_rst     = 1'b0;
    logic        din_vld   = 1'b0;
    logic [1:0]  pb_size   = 2'd0;
    logic [11:0] enable    = 12'd0;
    logic [11:0] pb_offset = 12'd0;
    logic [11:0] addr;
    logic        dout_vld;
    logic        last;
    logic        busy;
`ifdef TURBO_INTLV_CHK_EN
    logic        err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [11:0] mon_addr[$];
    bit          mon_last[$];
    int          mon_cyc[$];
    int          err_cyc[$];
    int          in_cyc[$];

    turbo_intlv_addr #(.AW(12), .LAT2(1)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .din_vld   (din_vld),
        .pb_size   (pb_size),
        .enable    (enable),
        .pb_offset (pb_offset),
        .addr      (addr),
        .dout_vld  (dout_vld),
        .last      (last),
        .busy      (busy)
`ifdef TURBO_INTLV_CHK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_vld === 1'b1) begin
            mon_addr.push_back(addr);
            mon_last.push_back(last);
            mon_cyc.push_back(cyc);
        end
`ifdef TURBO_INTLV_CHK_EN
        if (err === 1'b1) err_cyc.push_back(cyc);
`endif
    end

    function automatic int model_addr(input int x, input int l, input int base);
        int ofs [8];
        int step;
        ofs  = '{0, 24, 8, 40, 16, 56, 32, 48};
        step = (l == 64) ? 13 : ((l == 544) ? 25 : 17);
        return (base + ((step * x) + ofs[x % 8]) % l) % 4096;
    endfunction

    task automatic clear_q();
        mon_addr.delete();
        mon_last.delete();
        mon_cyc.delete();
        err_cyc.delete();
        in_cyc.delete();
    endtask

    // One clock of stimulus. Returns 1 ns after the sampling edge.
    task automatic beat(input bit v, input int x, input logic [1:0] sz, input int base);
        din_vld   = v;
        enable    = 12'(x);
        pb_size   = sz;
        pb_offset = 12'(base);
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        if (v) in_cyc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 0, pb_size, int'(pb_offset));
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (addr !== 12'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", addr); end
        checks++; if (dout_vld !== 1'b0) begin failures++; $display("FAIL reset_dout_vld: got %b expected 0", dout_vld); end
        checks++; if (last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b expected 0", last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef TURBO_INTLV_CHK_EN
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
        n_rst = 1'b1;
        clear_q();
        idle(3);
        checks++; if (mon_addr.size() != 0) begin failures++; $display("FAIL reset_quiet: got %0d outputs expected 0", mon_addr.size()); end
    endtask

    // PB16 with contiguous indices. pb_size flips to 2 halfway through, and
    // that change must be ignored while RUN.
    task automatic test_pb16();
        int  hand [8];
        bit  seen [64];
        int  n, ndist, nlast;
        hand = '{0, 37, 34, 15, 4, 57, 46, 11};
        clear_q();
        for (int x = 0; x < 64; x++) begin
            beat(1'b1, x, (x >= 32) ? 2'd2 : 2'd0, 0);
            if (x == 0) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pb16_busy_start: got %b expected 1", busy); end
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pb16_busy_end: got %b expected 0", busy); end
        idle(4);
        n = mon_addr.size();
        checks++; if (n != 64) begin failures++; $display("FAIL pb16_count: got %0d expected 64", n); end
        for (int i = 0; i < 8 && i < n; i++) begin
            checks++; if (int'(mon_addr[i]) != hand[i]) begin failures++; $display("FAIL pb16_hand[%0d]: got %0d expected %0d", i, mon_addr[i], hand[i]); end
        end
        ndist = 0; nlast = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int i = 0; i < n && i < 64; i++) begin
            checks++; if (int'(mon_addr[i]) != model_addr(i, 64, 0)) begin failures++; $display("FAIL pb16_addr[%0d]: got %0d expected %0d", i, mon_addr[i], model_addr(i, 64, 0)); end
            checks++; if (mon_cyc[i] - in_cyc[i] != 1) begin failures++; $display("FAIL pb16_latency[%0d]: got %0d expected 1", i, mon_cyc[i] - in_cyc[i]); end
            if (mon_addr[i] < 12'd64 && !seen[mon_addr[i]]) begin seen[mon_addr[i]] = 1'b1; ndist++; end
            if (mon_last[i]) nlast++;
        end
        checks++; if (ndist != 64) begin failures++; $display("FAIL pb16_distinct: got %0d expected 64", ndist); end
        checks++; if (nlast != 1) begin failures++; $display("FAIL pb16_last_count: got %0d expected 1", nlast); end
        if (n == 64) begin
            checks++; if (mon_last[63] !== 1'b1) begin failures++; $display("FAIL pb16_last_pos: got %b expected 1", mon_last[63]); end
        end
    endtask

    // PB520 at base 100 with random gaps between beats.
    task automatic test_pb520_gaps();
        bit seen [2080];
        int n, ndist, bad_model, bad_lat, nlast, rel;
        clear_q();
        for (int x = 0; x < 2080; x++) begin
            if (x > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            beat(1'b1, x, 2'd2, 100);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pb520_busy_end: got %b expected 0", busy); end
        idle(4);
        n = mon_addr.size();
        checks++; if (n != 2080) begin failures++; $display("FAIL pb520_count: got %0d expected 2080", n); end
        for (int i = 0; i < 2080; i++) seen[i] = 1'b0;
        ndist = 0; bad_model = 0; bad_lat = 0; nlast = 0;
        for (int i = 0; i < n && i < 2080; i++) begin
            rel = (int'(mon_addr[i]) - 100 + 4096) % 4096;
            if (rel < 2080 && !seen[rel]) begin seen[rel] = 1'b1; ndist++; end
            if (int'(mon_addr[i]) != model_addr(i, 2080, 100)) bad_model++;
            if (mon_cyc[i] - in_cyc[i] != 1) bad_lat++;
            if (mon_last[i]) nlast++;
        end
        checks++; if (ndist != 2080) begin failures++; $display("FAIL pb520_set: got %0d distinct expected 2080", ndist); end
        checks++; if (bad_model != 0) begin failures++; $display("FAIL pb520_addr: got %0d wrong expected 0", bad_model); end
        checks++; if (bad_lat != 0) begin failures++; $display("FAIL pb520_latency: got %0d wrong expected 0", bad_lat); end
        checks++; if (nlast != 1) begin failures++; $display("FAIL pb520_last_count: got %0d expected 1", nlast); end
        if (n == 2080) begin
            checks++; if (mon_last[2079] !== 1'b1) begin failures++; $display("FAIL pb520_last_pos: got %b expected 1", mon_last[2079]); end
        end
    endtask

    // PB136 at base 500, followed with no gap by PB16 at base 1000.
    task automatic test_back_to_back();
        int n, bad, nlast;
        clear_q();
        for (int x = 0; x < 544; x++) beat(1'b1, x, 2'd1, 500);
        for (int x = 0; x < 64; x++)  beat(1'b1, x, 2'd0, 1000);
        idle(4);
        n = mon_addr.size();
        checks++; if (n != 608) begin failures++; $display("FAIL b2b_count: got %0d expected 608", n); end
        bad = 0; nlast = 0;
        for (int i = 0; i < n && i < 608; i++) begin
            if (int'(mon_addr[i]) != ((i < 544) ? model_addr(i, 544, 500) : model_addr(i - 544, 64, 1000))) bad++;
            if (mon_last[i]) nlast++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL b2b_addr: got %0d wrong expected 0", bad); end
        checks++; if (nlast != 2) begin failures++; $display("FAIL b2b_last_count: got %0d expected 2", nlast); end
        if (n == 608) begin
            checks++; if (mon_cyc[544] - mon_cyc[543] != 1) begin failures++; $display("FAIL b2b_bubble: got gap %0d expected 1", mon_cyc[544] - mon_cyc[543]); end
            checks++; if (mon_addr[544] !== 12'd1000) begin failures++; $display("FAIL b2b_first: got %0d expected 1000", mon_addr[544]); end
            checks++; if (mon_addr[545] !== 12'd1037) begin failures++; $display("FAIL b2b_second: got %0d expected 1037", mon_addr[545]); end
            checks++; if (mon_last[543] !== 1'b1 || mon_last[607] !== 1'b1) begin failures++; $display("FAIL b2b_last_pos: got %b%b expected 11", mon_last[543], mon_last[607]); end
        end
    endtask

    // PB136 at base 4000: addresses wrap past 4095. The PB is left in RUN.
    task automatic test_wrap();
        int hand [5];
        hand = '{4000, 4049, 4058, 19, 20};
        clear_q();
        for (int x = 0; x < 5; x++) beat(1'b1, x, 2'd1, 4000);
        idle(3);
        checks++; if (mon_addr.size() != 5) begin failures++; $display("FAIL wrap_count: got %0d expected 5", mon_addr.size()); end
        for (int i = 0; i < 5 && i < mon_addr.size(); i++) begin
            checks++; if (int'(mon_addr[i]) != hand[i]) begin failures++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, mon_addr[i], hand[i]); end
            checks++; if (mon_last[i] !== 1'b0) begin failures++; $display("FAIL wrap_last[%0d]: got %b expected 0", i, mon_last[i]); end
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wrap_busy_gap: got %b expected 1", busy); end
    endtask

    // enable=0 while RUN: restart as PB16 at base 200.
    task automatic test_abort();
        int n, bad, nlast;
        clear_q();
        for (int x = 0; x < 64; x++) beat(1'b1, x, 2'd0, 200);
        idle(4);
        n = mon_addr.size();
        checks++; if (n != 64) begin failures++; $display("FAIL abort_count: got %0d expected 64", n); end
        if (n == 64) begin
            checks++; if (mon_addr[0] !== 12'd200) begin failures++; $display("FAIL abort_first: got %0d expected 200", mon_addr[0]); end
            checks++; if (mon_addr[1] !== 12'd237) begin failures++; $display("FAIL abort_second: got %0d expected 237", mon_addr[1]); end
            checks++; if (mon_addr[3] !== 12'd215) begin failures++; $display("FAIL abort_fourth: got %0d expected 215", mon_addr[3]); end
            checks++; if (mon_last[63] !== 1'b1) begin failures++; $display("FAIL abort_last_pos: got %b expected 1", mon_last[63]); end
        end
        bad = 0; nlast = 0;
        for (int i = 0; i < n && i < 64; i++) begin
            if (int'(mon_addr[i]) != model_addr(i, 64, 200)) bad++;
            if (mon_last[i]) nlast++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL abort_addr: got %0d wrong expected 0", bad); end
        checks++; if (nlast != 1) begin failures++; $display("FAIL abort_last_count: got %0d expected 1", nlast); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    endtask

    // Reset asserted in the middle of PB520, then restart.
    task automatic test_reset_mid();
        clear_q();
        for (int x = 0; x < 300; x++) beat(1'b1, x, 2'd2, 300);
        din_vld = 1'b1;
        enable  = 12'd300;
        #2 n_rst = 1'b0;
        #1;
        checks++; if (dout_vld !== 1'b0) begin failures++; $display("FAIL rstmid_dout_vld: got %b expected 0", dout_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        din_vld = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 n_rst = 1'b1;
        clear_q();
        beat(1'b1, 5, 2'd2, 300);
        idle(4);
        checks++; if (mon_addr.size() != 0) begin failures++; $display("FAIL rstmid_drop: got %0d outputs expected 0", mon_addr.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got %b expected 0", busy); end
        beat(1'b1, 0, 2'd2, 300);
        beat(1'b1, 1, 2'd2, 300);
        idle(4);
        checks++; if (mon_addr.size() != 2) begin failures++; $display("FAIL rstmid_restart_count: got %0d expected 2", mon_addr.size()); end
        if (mon_addr.size() == 2) begin
            checks++; if (mon_addr[0] !== 12'd300) begin failures++; $display("FAIL rstmid_first: got %0d expected 300", mon_addr[0]); end
            checks++; if (mon_addr[1] !== 12'd341) begin failures++; $display("FAIL rstmid_second: got %0d expected 341", mon_addr[1]); end
        end
    endtask

    // Skipped index (0,1,2,4). acc advances per beat, so x=4 gets 39+16=55.
    task automatic test_chk();
        int hand [4];
        hand = '{0, 37, 34, 55};
        n_rst = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b1;
        clear_q();
        beat(1'b1, 0, 2'd0, 0);
        beat(1'b1, 1, 2'd0, 0);
        beat(1'b1, 2, 2'd0, 0);
        beat(1'b1, 4, 2'd0, 0);
        idle(4);
        checks++; if (mon_addr.size() != 4) begin failures++; $display("FAIL chk_count: got %0d expected 4", mon_addr.size()); end
        for (int i = 0; i < 4 && i < mon_addr.size(); i++) begin
            checks++; if (int'(mon_addr[i]) != hand[i]) begin failures++; $display("FAIL chk_addr[%0d]: got %0d expected %0d", i, mon_addr[i], hand[i]); end
        end
`ifdef TURBO_INTLV_CHK_EN
        checks++; if (err_cyc.size() != 1) begin failures++; $display("FAIL chk_err_count: got %0d expected 1", err_cyc.size()); end
        if (err_cyc.size() == 1 && mon_cyc.size() == 4) begin
            checks++; if (err_cyc[0] != mon_cyc[3]) begin failures++; $display("FAIL chk_err_align: got cyc %0d expected %0d", err_cyc[0], mon_cyc[3]); end
        end
`endif
        n_rst = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b1;
        clear_q();
        beat(1'b1, 7, 2'd0, 0);
        idle(4);
        checks++; if (mon_addr.size() != 0) begin failures++; $display("FAIL chk_drop_out: got %0d outputs expected 0", mon_addr.size()); end
`ifdef TURBO_INTLV_CHK_EN
        checks++; if (err_cyc.size() != 1) begin failures++; $display("FAIL chk_drop_err_count: got %0d expected 1", err_cyc.size()); end
        if (err_cyc.size() == 1) begin
            checks++; if (err_cyc[0] != in_cyc[0] + 1) begin failures++; $display("FAIL chk_drop_err_time: got cyc %0d expected %0d", err_cyc[0], in_cyc[0] + 1); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_pb16();
        test_pb520_gaps();
        test_back_to_back();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_chk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
